pc_ebch_stream_encoder: RTL

// - Streaming product-code encoder; eBCH(N,K) is the component code for both rows and columns.
// - Accepts one K-bit information row per handshake.
// - Emits N encoded rows per frame: K systematic rows, then N-K-1 column-BCH parity rows, then 1 column overall-parity row.
// - Sits between the seed/PRBS source and the channel/decoder buffer.
// - Replaces the fixed 256/239, 16-wide block encoder with a parametrised, backpressured, frame-continuous version.

---
 rtl/pc_ebch_stream_encoder_pkg.sv | 37 +++
 rtl/pc_ebch_stream_encoder_row_parity.sv | 20 ++
 rtl/pc_ebch_stream_encoder.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/pc_ebch_stream_encoder_pkg.sv
// Shared definitions for the eBCH(N,K) product-code encoder, decoder and golden model.
// Holds the code geometry, the default generator polynomial, parity helpers and FSM encoding.
package pc_ebch_stream_encoder_pkg;

    localparam int N     = 256;
    localparam int K     = 239;
    localparam int R     = N - K - 1;
    localparam int IDX_W = $clog2(N);

    localparam logic [R:0] DEFAULT_GEN_POLY = 17'h16F63;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_PAR  = 2'd2,
        ST_EXT  = 2'd3
    } enc_state_e;

    // (info * x^R) mod g(x); gen_low is g(x) without its implicit x^R term.
    function automatic logic [R-1:0] bch_parity(input logic [K-1:0] info,
                                                input logic [R-1:0] gen_low);
        logic [R-1:0] rem;
        logic         fb;
        rem = {R{1'b0}};
        for (int i = K - 1; i >= 0; i--) begin
            fb  = info[i] ^ rem[R-1];
            rem = {rem[R-2:0], 1'b0} ^ (gen_low & {R{fb}});
        end
        return rem;
    endfunction

    // Extension bit that makes an N-bit eBCH word even weight.
    function automatic logic even_parity(input logic [N-2:0] bits);
        return ^bits;
    endfunction

endpackage

// File: rtl/pc_ebch_stream_encoder_row_parity.sv
// Combinational K -> N eBCH row encoder: {info, BCH parity, overall even parity}.
// Shared with the decoder's re-encode check.
module ebch_row_parity
    import pc_ebch_stream_encoder_pkg::*;
#(
    parameter logic [R:0] GEN = DEFAULT_GEN_POLY
) (
    input  logic [K-1:0] info,
    output logic [N-1:0] codeword
);

    logic [R-1:0] parity_s;

    // Systematic codeword assembly
    always_comb begin
        parity_s = bch_parity(info, GEN[R-1:0]);
        codeword = {info, parity_s, even_parity({info, parity_s})};
    end

endmodule

// File: rtl/pc_ebch_stream_encoder.sv
// Streaming eBCH(N,K) product-code encoder: K systematic rows, R column-parity rows and
// one column extension row per frame, with valid/ready handshakes on both sides.
module pc_ebch_stream_encoder
    import pc_ebch_stream_encoder_pkg::*;
#(
    parameter logic [R:0] GEN_POLY = DEFAULT_GEN_POLY
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [K-1:0]     in_row,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_row,
    output logic             out_first,
    output logic             out_last,
    output logic [IDX_W-1:0] row_idx
);

    localparam logic [IDX_W-1:0] LAST_INFO_IDX = IDX_W'(K - 1);
    localparam logic [IDX_W-1:0] LAST_PAR_IDX  = IDX_W'(K + R - 1);
    localparam logic [IDX_W-1:0] ONE_IDX       = IDX_W'(1);

    enc_state_e          state_r;
    enc_state_e          next_state_s;
    logic [R-1:0][N-1:0] col_r;
    logic [R-1:0][N-1:0] col_lfsr_s;
    logic [N-1:0]        ext_r;
    logic [N-1:0]        enc_row_s;
    logic [N-1:0]        fb_s;
    logic [N-1:0]        load_row_s;
    logic [IDX_W-1:0]    cnt_r;
    logic                slot_free_s;
    logic                accept_s;
    logic                load_s;

    ebch_row_parity #(
        .GEN (GEN_POLY)
    ) u_row_parity (
        .info     (in_row),
        .codeword (enc_row_s)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic; a blocked output slot freezes every transition
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) next_state_s = ST_DATA;
                else          next_state_s = ST_IDLE;
            end
            ST_DATA: begin
                if (accept_s && (cnt_r == LAST_INFO_IDX)) next_state_s = ST_PAR;
                else                                      next_state_s = ST_DATA;
            end
            ST_PAR: begin
                if (slot_free_s && (cnt_r == LAST_PAR_IDX)) next_state_s = ST_EXT;
                else                                        next_state_s = ST_PAR;
            end
            ST_EXT: begin
                if (slot_free_s) next_state_s = ST_IDLE;
                else             next_state_s = ST_EXT;
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // FSM output decode: input handshake and the row offered to the output register
    always_comb begin
        slot_free_s = !out_valid || out_ready;
        in_ready    = 1'b0;
        load_row_s  = enc_row_s;
        case (state_r)
            ST_IDLE, ST_DATA: begin
                in_ready   = !reset && slot_free_s;
                load_row_s = enc_row_s;
            end
            ST_PAR: begin
                in_ready   = 1'b0;
                load_row_s = col_r[R-1];
            end
            ST_EXT: begin
                in_ready   = 1'b0;
                load_row_s = ext_r;
            end
            default: begin
                in_ready   = 1'b0;
                load_row_s = enc_row_s;
            end
        endcase
        accept_s = in_valid && in_ready;
        load_s   = accept_s || (slot_free_s && ((state_r == ST_PAR) || (state_r == ST_EXT)));
    end

    // Column LFSR step: one bit-serial BCH division step on all N columns at once
    always_comb begin
        fb_s          = enc_row_s ^ col_r[R-1];
        col_lfsr_s[0] = fb_s & {N{GEN_POLY[0]}};
        for (int i = 1; i < R; i++) begin
            col_lfsr_s[i] = col_r[i-1] ^ (fb_s & {N{GEN_POLY[i]}});
        end
    end

    // Column remainders, extension accumulator and row counter
    always_ff @(posedge clk) begin
        if (reset) begin
            col_r <= {(R * N){1'b0}};
            ext_r <= {N{1'b0}};
            cnt_r <= {IDX_W{1'b0}};
        end else if (load_s) begin
            case (state_r)
                ST_IDLE, ST_DATA: begin
                    col_r <= col_lfsr_s;
                    ext_r <= ext_r ^ load_row_s;
                    cnt_r <= cnt_r + ONE_IDX;
                end
                ST_PAR: begin
                    col_r <= {col_r[R-2:0], {N{1'b0}}};
                    ext_r <= ext_r ^ load_row_s;
                    cnt_r <= cnt_r + ONE_IDX;
                end
                ST_EXT: begin
                    col_r <= {(R * N){1'b0}};
                    ext_r <= {N{1'b0}};
                    cnt_r <= {IDX_W{1'b0}};
                end
                default: begin
                    col_r <= {(R * N){1'b0}};
                    ext_r <= {N{1'b0}};
                    cnt_r <= {IDX_W{1'b0}};
                end
            endcase
        end else begin
            col_r <= col_r;
            ext_r <= ext_r;
            cnt_r <= cnt_r;
        end
    end

    // Output register: holds its row until the downstream accepts it
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_row   <= {N{1'b0}};
            out_first <= 1'b0;
            out_last  <= 1'b0;
            row_idx   <= {IDX_W{1'b0}};
        end else if (load_s) begin
            out_valid <= 1'b1;
            out_row   <= load_row_s;
            out_first <= (state_r == ST_IDLE);
            out_last  <= (state_r == ST_EXT);
            row_idx   <= cnt_r;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= out_valid;
        end
    end

endmodule
